// File: rtl/spike_decoder.sv
// Spike decoder: converts a neuron spike level back into magnitude form.
// Produces a decaying synaptic current trace (chainable into a neuron
// `current` input) and a windowed firing-rate count on a valid/ready port.
// Optional inter-spike-interval measurement is built only when the macro
// SPIKE_DECODER_ISI_EN is defined; otherwise `isi`/`isi_valid` are tied to 0.
module spike_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             spike,
  input  logic [WIDTH-1:0] weight,
  output logic [WIDTH-1:0] current,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
);

  localparam int unsigned      WinW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic             spike_q;
  logic [WIDTH-1:0] trace_q, trace_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH:0]   trace_ext, dec, sum;
  logic             spk_edge, run, hs;

  // A level held high is a single event; spike_q tracks even while idle.
  assign spk_edge = spike & ~spike_q;
  assign run      = (state_q == StRun);
  assign hs       = rate_valid_q & rate_ready;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  // Next-state logic for the run/idle FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en)  state_d = StRun;
      StRun:   if (!en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Trace: decay by trace>>DECAY_SHIFT (at least 1 while nonzero), add weight
  // on an edge, saturate; the extra MSB catches the overflow.
  always_comb begin
    trace_ext = {1'b0, trace_q};
    dec       = trace_ext >> DECAY_SHIFT;
    if (trace_q != '0 && dec == '0) dec = {{WIDTH{1'b0}}, 1'b1};
    sum       = trace_ext - dec + (spk_edge ? {1'b0, weight} : '0);
    trace_d   = trace_q;
    if (run) trace_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  // Rate window, event counter and valid/ready/overrun bookkeeping.
  always_comb begin
    win_d        = win_q;
    cnt_d        = cnt_q;
    rate_d       = rate_q;
    rate_valid_d = rate_valid_q;
    overrun_d    = overrun_q;
    if (hs) begin
      rate_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (run) begin
      if (win_q == WinLast) begin
        win_d        = '0;
        cnt_d        = '0;
        rate_d       = spk_edge ? cnt_inc : cnt_q;
        rate_valid_d = 1'b1;
        // A completing window only overruns if the old value was not taken.
        if (rate_valid_q && !hs) overrun_d = 1'b1;
      end else begin
        win_d = win_q + 1'b1;
        if (spk_edge) cnt_d = cnt_inc;
      end
      // Leaving RUN restarts the window from zero.
      if (!en) begin
        win_d = '0;
        cnt_d = '0;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      spike_q      <= 1'b0;
      trace_q      <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      spike_q      <= spike;
      trace_q      <= trace_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign current    = trace_q;
  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign overrun    = overrun_q;

`ifdef SPIKE_DECODER_ISI_EN
  logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d, isi_cnt_inc;
  logic [CNT_W-1:0] isi_q, isi_d;
  logic             armed_q, armed_d;
  logic             isi_valid_q, isi_valid_d;

  assign isi_cnt_inc = (isi_cnt_q == CntMax) ? isi_cnt_q : isi_cnt_q + 1'b1;

  // ISI counter: first edge arms, later edges report counter+1 and restart.
  always_comb begin
    isi_cnt_d   = isi_cnt_q;
    isi_d       = isi_q;
    armed_d     = armed_q;
    isi_valid_d = 1'b0;
    if (run) begin
      if (spk_edge) begin
        if (armed_q) begin
          isi_d       = isi_cnt_inc;
          isi_valid_d = 1'b1;
        end
        armed_d   = 1'b1;
        isi_cnt_d = '0;
      end else if (armed_q) begin
        isi_cnt_d = isi_cnt_inc;
      end
      if (!en) begin
        armed_d   = 1'b0;
        isi_cnt_d = '0;
      end
    end
  end

  // ISI registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isi_cnt_q   <= '0;
      isi_q       <= '0;
      armed_q     <= 1'b0;
      isi_valid_q <= 1'b0;
    end else begin
      isi_cnt_q   <= isi_cnt_d;
      isi_q       <= isi_d;
      armed_q     <= armed_d;
      isi_valid_q <= isi_valid_d;
    end
  end

  assign isi       = isi_q;
  assign isi_valid = isi_valid_q;
`else
  assign isi       = '0;
  assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_decoder.sv
// Scoreboard bench for spike_decoder: stimulus schedules expected values,
// monitors pop and compare them at negedges (and right after reset rises).
module tb_spike_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       spike = 1'b0;
  logic       rate_ready = 1'b0;
  logic [7:0] weight = 8'd0;
  logic [7:0] current, rate, isi;
  logic       rate_valid, overrun, isi_valid;

  spike_decoder #(
    .WIDTH(8), .CNT_W(8), .WINDOW(256), .DECAY_SHIFT(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .spike     (spike),
    .weight    (weight),
    .current   (current),
    .rate      (rate),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun   (overrun),
    .isi       (isi),
    .isi_valid (isi_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int sel; int val;} chk_t;
  chk_t chk_q[$];
  int   rate_exp_q[$];
  int   isi_exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int sample(int sel);
    case (sel)
      0:       return int'(current);
      1:       return int'(rate);
      2:       return int'(rate_valid);
      3:       return int'(overrun);
      4:       return int'(isi);
      default: return int'(isi_valid);
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0:       return "current";
      1:       return "rate";
      2:       return "rate_valid";
      3:       return "overrun";
      4:       return "isi";
      default: return "isi_valid";
    endcase
  endfunction

  task automatic compare(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Sorted insert so tests may schedule checks in any order.
  task automatic exp_at(int c, int sel, int v);
    chk_t e;
    int   i;
    e = '{c, sel, v};
    i = 0;
    while (i < chk_q.size() && chk_q[i].cyc <= c) i++;
    chk_q.insert(i, e);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) tick(1);
  endtask

  // Timed-value monitor.
  always begin
    chk_t e;
    @(negedge clk or posedge reset);
    #1;
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      e = chk_q.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s scheduled cyc %0d missed (now %0d)", sel_name(e.sel), e.cyc, cyc);
      end else begin
        compare(sel_name(e.sel), sample(e.sel), e.val);
      end
    end
  end

  // Transfer monitor: rate on handshake, isi on valid pulse.
  always begin
    @(negedge clk);
    #1;
    if (rate_valid && rate_ready) begin
      if (rate_exp_q.size() == 0) compare("unexpected_rate_xfer", int'(rate), -1);
      else compare("rate_xfer", int'(rate), rate_exp_q.pop_front());
    end
    if (isi_valid) begin
      if (isi_exp_q.size() == 0) compare("unexpected_isi", int'(isi), -1);
      else compare("isi_xfer", int'(isi), isi_exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t, x, e;
    // Reset values.
    tick(2);
    for (int s = 0; s < 6; s++) exp_at(cyc, s, 0);
    tick(1);
    reset = 1'b0;
    en = 1'b1;
    rate_ready = 1'b1;
    c0 = cyc;  // RUN from posedge c0+1, window cycle 0 at posedge c0+2

    // Decay from a single weight-64 edge.
    tick(1);
    weight = 8'd64;
    spike = 1'b1;
    exp_at(c0 + 2, 0, 64);
    exp_at(c0 + 3, 0, 56);
    exp_at(c0 + 4, 0, 49);
    exp_at(c0 + 5, 0, 43);
    exp_at(c0 + 100, 0, 0);
    exp_at(c0 + 110, 0, 0);
    tick(1);
    spike = 1'b0;

    // Saturation: edges at t and t+2 with weight 200.
    wait_cyc(c0 + 120);
    t = cyc;
    weight = 8'd200;
    spike = 1'b1;
    exp_at(t + 1, 0, 200);
    exp_at(t + 2, 0, 175);
    exp_at(t + 3, 0, 255);
    tick(1);
    spike = 1'b0;
    tick(1);
    spike = 1'b1;
    tick(1);
    spike = 1'b0;

    // Window 0 holds 3 edges; window 1 one edge every 4 cycles.
    rate_exp_q.push_back(3);
    exp_at(c0 + 257, 1, 3);
    exp_at(c0 + 257, 2, 1);
    exp_at(c0 + 258, 2, 0);
    exp_at(c0 + 512, 2, 0);
    exp_at(c0 + 513, 2, 1);
    exp_at(c0 + 514, 2, 0);
    rate_exp_q.push_back(64);
    wait_cyc(c0 + 257);
    for (int i = 0; i < 64; i++) begin
      spike = 1'b1;
      tick(2);
      spike = 1'b0;
      tick(2);
    end

    // Window 2: spike held high throughout counts once.
    spike = 1'b1;
    rate_exp_q.push_back(1);
    wait_cyc(c0 + 769);
    spike = 1'b0;
    tick(1);
    rate_ready = 1'b0;

    // Overrun: windows 3 and 4 carry 10 and 20 edges, nothing accepted.
    for (int i = 0; i < 10; i++) begin
      spike = 1'b1;
      tick(2);
      spike = 1'b0;
      tick(2);
    end
    exp_at(c0 + 1025, 1, 10);
    exp_at(c0 + 1025, 2, 1);
    exp_at(c0 + 1025, 3, 0);
    exp_at(c0 + 1281, 1, 20);
    exp_at(c0 + 1281, 2, 1);
    exp_at(c0 + 1281, 3, 1);
    wait_cyc(c0 + 1025);
    for (int i = 0; i < 20; i++) begin
      spike = 1'b1;
      tick(2);
      spike = 1'b0;
      tick(2);
    end
    wait_cyc(c0 + 1283);
    rate_exp_q.push_back(20);
    exp_at(c0 + 1284, 2, 0);
    exp_at(c0 + 1284, 3, 0);
    exp_at(c0 + 1285, 2, 0);
    rate_ready = 1'b1;
    tick(1);
    rate_ready = 1'b0;

    // Asynchronous reset while current = 120.
    wait_cyc(c0 + 1300);
    weight = 8'd120;
    spike = 1'b1;
    exp_at(cyc + 1, 0, 120);
    tick(1);
    spike = 1'b0;
    @(negedge clk);
    #2;
    for (int s = 0; s < 6; s++) exp_at(cyc, s, 0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    x = cyc;

    // Enable drop: trace holds, window restarts, held spike not counted.
    tick(1);
    weight = 8'd80;
    spike = 1'b1;
    exp_at(x + 2, 0, 80);
    exp_at(x + 3, 0, 70);
    exp_at(x + 10, 0, 70);
    exp_at(x + 19, 0, 70);
    exp_at(x + 276, 2, 0);
    exp_at(x + 277, 2, 1);
    exp_at(x + 277, 1, 0);
    exp_at(x + 277, 3, 0);
    tick(1);
    spike = 1'b0;
    en = 1'b0;
    wait_cyc(x + 8);
    spike = 1'b1;
    wait_cyc(x + 20);
    en = 1'b1;

    // ISI: edges 10 and 35 cycles after en rises.
    wait_cyc(x + 280);
    spike = 1'b0;
    en = 1'b0;
    tick(3);
    en = 1'b1;
    e = cyc;
`ifdef SPIKE_DECODER_ISI_EN
    isi_exp_q.push_back(25);
    exp_at(e + 10, 5, 0);
    exp_at(e + 35, 4, 25);
    exp_at(e + 35, 5, 1);
    exp_at(e + 36, 5, 0);
`else
    exp_at(e + 35, 4, 0);
    exp_at(e + 35, 5, 0);
    exp_at(e + 36, 4, 0);
`endif
    wait_cyc(e + 9);
    spike = 1'b1;
    tick(1);
    spike = 1'b0;
    wait_cyc(e + 34);
    spike = 1'b1;
    tick(1);
    spike = 1'b0;
    tick(5);

    // Anything still queued was never observed.
    compare("pending_checks", chk_q.size(), 0);
    compare("pending_rate", rate_exp_q.size(), 0);
    compare("pending_isi", isi_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
